// File: rtl/rule110_seed_loader.sv
// rule110_seed_loader
// Front end of the 512-cell Rule 110 automaton. It collects a stream of
// WORD_W-bit seed words into the CELLS-wide data bus and then issues a
// one-cycle load strobe.
// Optional feature macro: RULE110_LOADER_CNT_EN. When it is defined, the block
// adds a RUN state that counts the generations after each load. It then reports
// done when gen_limit is reached. The default build leaves the macro undefined,
// and the loader then returns to IDLE straight after the load cycle.
module rule110_seed_loader #(
  parameter int WORD_W = 32,
  parameter int CELLS  = 512
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_last,
`ifdef RULE110_LOADER_CNT_EN
  input  logic [15:0]       gen_limit,
  output logic [15:0]       gen_count,
  output logic              done,
`endif
  output logic              load,
  output logic [CELLS-1:0]  data,
  output logic              busy,
  output logic              frame_short
);

  localparam int BEATS  = CELLS / WORD_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

`ifdef RULE110_LOADER_CNT_EN
  typedef enum logic [1:0] {IDLE, FILL, LOAD, RUN} state_t;
`else
  typedef enum logic [1:0] {IDLE, FILL, LOAD} state_t;
`endif

  state_t            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [CELLS-1:0]  data_q, data_d;
  logic              load_q, load_d;
  logic              short_q, short_d;
`ifdef RULE110_LOADER_CNT_EN
  logic [15:0]       limit_q, limit_d;
  logic [15:0]       count_q, count_d;
  logic              done_q, done_d;
`endif

  logic              accept;
  logic              first_beat;
  logic [BEAT_W-1:0] cur_beat;
  logic              frame_end;

  // Only LOAD refuses words. Every state except IDLE counts as busy.
  assign s_ready    = (state_q != LOAD);
  assign busy       = (state_q != IDLE);
  assign accept     = s_valid && s_ready;
  // Any word taken outside FILL opens a new frame and always lands in slot 0.
  assign first_beat = accept && (state_q != FILL);
  assign cur_beat   = first_beat ? '0 : beat_q;
  assign frame_end  = accept && (s_last || (cur_beat == LAST_BEAT));

  genvar gi;
  generate
    for (gi = 0; gi < BEATS; gi++) begin : g_word
      // Each word slot takes the accepted word when its index matches.
      // A frame's first beat also clears the slot.
      assign data_d[gi*WORD_W +: WORD_W] =
          (accept && (cur_beat == BEAT_W'(gi))) ? s_data :
          first_beat                            ? {WORD_W{1'b0}} :
                                                  data_q[gi*WORD_W +: WORD_W];
    end
  endgenerate

  // Next-state logic: frame assembly, load strobe and generation counting.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    load_d  = 1'b0;
    short_d = 1'b0;
`ifdef RULE110_LOADER_CNT_EN
    limit_d = limit_q;
    count_d = count_q;
    done_d  = 1'b0;
`endif
    case (state_q)
      LOAD: begin
`ifdef RULE110_LOADER_CNT_EN
        state_d = RUN;
        limit_d = gen_limit;
        count_d = 16'd0;
`else
        state_d = IDLE;
`endif
      end
`ifdef RULE110_LOADER_CNT_EN
      RUN: begin
        // An accepted word aborts the run. The count freezes and no done is produced.
        if (!accept) begin
          if ((limit_q != 16'd0) && (count_q == limit_q - 16'd1)) begin
            count_d = limit_q;
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (count_q != 16'hFFFF) begin
            count_d = count_q + 16'd1;
          end
        end
      end
`endif
      default: ;
    endcase
    if (accept) begin
      if (frame_end) begin
        state_d = LOAD;
        load_d  = 1'b1;
        short_d = (cur_beat != LAST_BEAT);
        beat_d  = '0;
      end else begin
        state_d = FILL;
        beat_d  = cur_beat + 1'b1;
      end
    end
  end

  // State register. The asynchronous reset discards any partial frame.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      data_q  <= '0;
      load_q  <= 1'b0;
      short_q <= 1'b0;
`ifdef RULE110_LOADER_CNT_EN
      limit_q <= 16'd0;
      count_q <= 16'd0;
      done_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      data_q  <= data_d;
      load_q  <= load_d;
      short_q <= short_d;
`ifdef RULE110_LOADER_CNT_EN
      limit_q <= limit_d;
      count_q <= count_d;
      done_q  <= done_d;
`endif
    end
  end

  assign load        = load_q;
  assign data        = data_q;
  assign frame_short = short_q;
`ifdef RULE110_LOADER_CNT_EN
  assign gen_count   = count_q;
  assign done        = done_q;
`endif

endmodule

// File: tb/tb_rule110_seed_loader.sv
// Bench for rule110_seed_loader. Frames come from a vector table plus a few
// hand-written sequences for the run/abort/reset corner cases. A scoreboard
// queues each expected load (and, with RULE110_LOADER_CNT_EN, each expected
// done) at the edge the final word is accepted. A monitor on the falling edge
// pops and compares the queued entries.
module tb_rule110_seed_loader;

  logic         clk;
  logic         areset;
  logic         s_valid;
  logic         s_ready;
  logic [31:0]  s_data;
  logic         s_last;
  logic         load;
  logic [511:0] data;
  logic         busy;
  logic         frame_short;
`ifdef RULE110_LOADER_CNT_EN
  logic [15:0]  gen_limit;
  logic [15:0]  gen_count;
  logic         done;
`endif

  rule110_seed_loader #(.WORD_W(32), .CELLS(512)) dut (
    .clk         (clk),
    .areset      (areset),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_last      (s_last),
`ifdef RULE110_LOADER_CNT_EN
    .gen_limit   (gen_limit),
    .gen_count   (gen_count),
    .done        (done),
`endif
    .load        (load),
    .data        (data),
    .busy        (busy),
    .frame_short (frame_short)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int           cyc;
    logic [511:0] data;
    logic         short_f;
  } load_exp_t;

  typedef struct {
    int          cyc;
    logic [15:0] cnt;
  } done_exp_t;

  typedef struct {
    int          nbeats;
    logic [31:0] w0;
    logic [31:0] step;
    bit          use_last;
    bit          toggle;
    bit          exp_short;
  } vec_t;

  load_exp_t load_q[$];
  done_exp_t done_q[$];
  load_exp_t mon_le;
  done_exp_t mon_de;
  vec_t      vecs[6];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one word and hold it until the handshake completes.
  // The task is entered and left just after a rising edge.
  task automatic send_beat(input logic [31:0] d, input logic last, output int acc_cyc);
    int   guard;
    logic took;
    guard   = 0;
    took    = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (!took && guard < 50) begin
      @(negedge clk);
      took = s_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 32'hDEADBEEF;
    if (!took) chk("beat_accept_timeout", 512'(0), 512'(1));
    acc_cyc = cyc;
  endtask

  // Send a frame and queue the load (and done) it should produce.
  // Word 0 is w0. Word k>0 is step*k.
  task automatic send_frame(input int nbeats, input logic [31:0] w0, input logic [31:0] step,
                            input bit use_last, input bit toggle, input bit exp_short,
                            input logic [15:0] limit, output int acc_cyc);
    logic [511:0] model;
    logic [31:0]  w;
    int           c;
    load_exp_t    le;
`ifdef RULE110_LOADER_CNT_EN
    done_exp_t    de;
    gen_limit = limit;
`endif
    model = '0;
    c = 0;
    for (int k = 0; k < nbeats; k++) begin
      w = (k == 0) ? w0 : step * 32'(k);
      model[k*32 +: 32] = w;
      send_beat(w, use_last && (k == nbeats - 1), c);
      if (toggle && (k != nbeats - 1)) wait_cycles(1);
    end
    le.cyc     = c;
    le.data    = model;
    le.short_f = exp_short;
    load_q.push_back(le);
`ifdef RULE110_LOADER_CNT_EN
    if (limit != 16'd0) begin
      de.cyc = c + 1 + int'(limit);
      de.cnt = limit;
      done_q.push_back(de);
    end
`endif
    acc_cyc = c;
  endtask

  // Monitor: sample away from the active edge and retire scoreboard entries.
  initial begin
    forever begin
      @(negedge clk);
      if (!areset) begin
        if (load) begin
          if (load_q.size() == 0) begin
            chk("unexpected_load", 512'(1), 512'(0));
          end else begin
            mon_le = load_q.pop_front();
            chk("load_cycle", 512'(cyc), 512'(mon_le.cyc));
            chk("load_data", data, mon_le.data);
            chk("load_frame_short", 512'(frame_short), 512'(mon_le.short_f));
            chk("s_ready_in_load", 512'(s_ready), 512'(0));
            chk("busy_in_load", 512'(busy), 512'(1));
          end
        end else if (frame_short) begin
          chk("stray_frame_short", 512'(1), 512'(0));
        end
`ifdef RULE110_LOADER_CNT_EN
        if (done) begin
          if (done_q.size() == 0) begin
            chk("unexpected_done", 512'(1), 512'(0));
          end else begin
            mon_de = done_q.pop_front();
            chk("done_cycle", 512'(cyc), 512'(mon_de.cyc));
            chk("done_gen_count", 512'(gen_count), 512'(mon_de.cnt));
          end
        end
`endif
      end
    end
  end

  int n;
  int m;

  initial begin
    vecs[0] = '{16, 32'hA5A5A5A5, 32'h11111111, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{3,  32'h000004DF, 32'h00000001, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{16, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1,  32'hCAFEF00D, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{15, 32'h12345678, 32'h01010101, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{16, 32'hFFFFFFFF, 32'h0F0F0F0F, 1'b1, 1'b0, 1'b0};

    areset  = 1'b1;
    s_valid = 1'b0;
    s_data  = 32'h0;
    s_last  = 1'b0;
`ifdef RULE110_LOADER_CNT_EN
    gen_limit = 16'd0;
`endif

    // Reset values.
    @(negedge clk);
    @(negedge clk);
    chk("rst_load", 512'(load), 512'(0));
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_frame_short", 512'(frame_short), 512'(0));
    chk("rst_data", data, 512'(0));
`ifdef RULE110_LOADER_CNT_EN
    chk("rst_gen_count", 512'(gen_count), 512'(0));
    chk("rst_done", 512'(done), 512'(0));
`endif
    areset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_s_ready", 512'(s_ready), 512'(1));

    // Table-driven frames. Counting is unbounded, so each frame aborts the previous run.
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].nbeats, vecs[i].w0, vecs[i].step, vecs[i].use_last,
                 vecs[i].toggle, vecs[i].exp_short, 16'd0, n);
      wait_cycles(2);
    end

    // Seed = 1 with s_valid held high and a limit of 10. Afterwards the loader is idle.
    send_frame(16, 32'h00000001, 32'h0, 1'b1, 1'b0, 1'b0, 16'd10, n);
    wait_cycles(15);
    chk("idle_after_limit10", 512'(busy), 512'(0));

    // Limit 1: done follows the first RUN cycle.
    send_frame(2, 32'h0BADCAFE, 32'h00000777, 1'b1, 1'b0, 1'b1, 16'd1, n);
    wait_cycles(5);
    chk("idle_after_limit1", 512'(busy), 512'(0));

`ifdef RULE110_LOADER_CNT_EN
    // Unbounded run aborted by a 1-beat frame. The count freezes at 50.
    send_frame(16, 32'h00000F0F, 32'h00000003, 1'b0, 1'b0, 1'b0, 16'd0, n);
    while (cyc < n + 51) begin
      @(posedge clk);
      #1;
    end
    send_frame(1, 32'h600DF00D, 32'h0, 1'b1, 1'b0, 1'b1, 16'd0, m);
    @(negedge clk);
    chk("abort_gen_count", 512'(gen_count), 512'(50));
    chk("abort_accept_cycle", 512'(m), 512'(n + 52));
    @(posedge clk);
    #1;
`endif

    // Reset in the middle of a frame after 8 of 16 words.
    for (int k = 0; k < 8; k++) send_beat(32'hBAD00000 + 32'(k), 1'b0, m);
    areset = 1'b1;
    #2;
    chk("mid_rst_load", 512'(load), 512'(0));
    chk("mid_rst_busy", 512'(busy), 512'(0));
    chk("mid_rst_frame_short", 512'(frame_short), 512'(0));
    chk("mid_rst_data", data, 512'(0));
    chk("mid_rst_s_ready", 512'(s_ready), 512'(1));
`ifdef RULE110_LOADER_CNT_EN
    chk("mid_rst_gen_count", 512'(gen_count), 512'(0));
    chk("mid_rst_done", 512'(done), 512'(0));
`endif
    @(negedge clk);
    areset = 1'b0;
    @(posedge clk);
    #1;
    send_frame(16, 32'h13579BDF, 32'h02468ACE, 1'b1, 1'b0, 1'b0, 16'd0, n);
    wait_cycles(2);
    send_frame(4, 32'h0000ABCD, 32'h10000001, 1'b1, 1'b1, 1'b1, 16'd0, n);
    wait_cycles(5);

    chk("pending_loads", 512'(load_q.size()), 512'(0));
    chk("pending_dones", 512'(done_q.size()), 512'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rule110_seed_loader.md
# rule110_seed_loader

Upstream stage of the 512-cell Rule 110 automaton. It accepts a seed pattern as a stream of 32-bit words with a valid/ready handshake and assembles them into the 512-bit `data` bus. It then drives a single-cycle `load` pulse into the automaton and counts the generations the automaton runs after loading. It signals `done` once a programmed generation count is reached.

## Interface
Parameters:
- `WORD_W`, 32: stream word width.
- `CELLS`, 512: automaton width. Must be a multiple of `WORD_W`. `BEATS = CELLS/WORD_W` (16).

Ports (one clock; reset is asynchronous and active-high):
- `clk`, in, 1: clock; all state changes on the rising edge.
- `areset`, in, 1: asynchronous, active-high reset.
- `s_valid`, in, 1: stream word valid.
- `s_ready`, out, 1: loader can accept a word.
- `s_data`, in, `WORD_W`: stream word.
- `s_last`, in, 1: final word of the frame.
- `gen_limit`, in, 16: generations to run after the load; 0 = unbounded. Present only with `RULE110_LOADER_CNT_EN`.
- `load`, out, 1: one-cycle load strobe to the automaton.
- `data`, out, `CELLS`: assembled seed.
- `busy`, out, 1: high in FILL, LOAD and RUN.
- `frame_short`, out, 1: one-cycle pulse when a frame ends before `BEATS` words.
- `gen_count`, out, 16: generations elapsed since the load. Present only with `RULE110_LOADER_CNT_EN`.
- `done`, out, 1: one-cycle pulse when `gen_count` reaches `gen_limit`. Present only with `RULE110_LOADER_CNT_EN`.

## Operation
- States: IDLE, FILL, LOAD, RUN.
- Beat accepted = `s_valid && s_ready`. `s_ready` is 1 in IDLE, FILL and RUN, and 0 in LOAD.
- Beat index `k` (0..BEATS-1) writes `data[k*WORD_W +: WORD_W]`. Beat 0 is the LSBs.
- When the first beat of a frame is accepted (state IDLE or RUN), all other words of `data` are cleared to 0 at the same edge.
- A frame ends on an accepted beat with `s_last=1`, or on accepted beat `BEATS-1`, whichever comes first.
  - An `s_last` absent on beat `BEATS-1` is ignored. The frame still ends there.
  - If the frame ends with `k < BEATS-1`, the upper words stay 0 and `frame_short` pulses.
- State transitions:
  - IDLE -> FILL on an accepted beat that does not end the frame.
  - IDLE or FILL -> LOAD on the accepted beat that ends the frame. A 1-beat frame goes IDLE -> LOAD directly.
  - LOAD -> RUN unconditionally after one cycle. `gen_limit` is sampled on that edge and `gen_count` is cleared to 0.
  - In RUN, each edge increments `gen_count`. At the edge where `gen_count == gen_limit-1` and `gen_limit != 0`: `gen_count <= gen_limit`, `done <= 1`, state <= IDLE. With `gen_limit = 0`, RUN persists and `gen_count` saturates at 0xFFFF.
  - In RUN, an accepted beat aborts the run. No `done` is produced, a new frame starts (RUN -> FILL, or RUN -> LOAD for a 1-beat frame), and `gen_count` holds its value.
- `data` changes only on accepted beats. It is stable throughout LOAD and RUN.

## Timing
- Reset values: state IDLE, `data=0`, `load=0`, `busy=0`, `frame_short=0`, `gen_count=0`, `done=0`, beat index 0. `s_ready=1` once reset is released.
- `areset` asserted mid-frame or mid-run returns to IDLE immediately. The partial frame is discarded.
- Final beat accepted at edge N:
  - `load=1` for exactly the cycle N..N+1, with the final `data` valid.
  - `frame_short` is high in the same cycle when applicable.
- The automaton captures the seed at edge N+1.
- With `gen_limit=L>0`: `done` is high during cycle N+1+L .. N+2+L. In that cycle the automaton's `q` holds generation L and `gen_count=L`.
- `load`, `done` and `frame_short` are registered outputs. `s_ready` and `busy` are decoded from state.

## Configuration
- `RULE110_LOADER_CNT_EN` defined: RUN state, `gen_limit`, `gen_count` and `done` are present as described above.
- Not defined: those ports and the RUN state are removed, and LOAD -> IDLE directly. `busy` is high in FILL and LOAD only. A new frame may start in the cycle after `load`.

## Test plan
- 16 beats of 0x00000000 except beat 0 = 0x00000001, `gen_limit=10`, `s_valid` held high -> one `load` pulse with `data=1`; `done` exactly 10 cycles after the `load` cycle with `gen_count=10`.
- 3-beat frame 0x4DF, 0x1, 0x2 with `s_last` on beat 2 -> `data[95:0]` = {0x2, 0x1, 0x4DF}, upper bits 0, `frame_short=1` coincident with `load`.
- `s_valid` toggling every other cycle over a 16-beat frame -> only handshaked words are written; exactly one `load`; `s_ready=0` during the `load` cycle.
- `gen_limit=0`, new 1-beat frame (`s_last=1`) injected 50 cycles into RUN -> no `done`; `gen_count` holds 50; second `load` one cycle later.
- `areset` pulsed after beat 7 of 16 -> all outputs return to reset values; the next full frame loads correctly with no stale words.
- `gen_limit=1` -> `done` in the cycle immediately after the first RUN cycle; state returns to IDLE.
